// File: rtl/pma_region_table.sv
// rtl/pma_region_table.sv - runtime-programmable physical-memory-attribute region table
//
// Classifies one physical address per cycle against NrRules base/length
// regions and returns {exec, nonidem, cached} of the lowest-indexed match.
// The result sits in a single registered slot with valid/ready handshaking.
// A config write port reprograms entries at run time.
//
// Optional feature macro: PMA_REGION_TABLE_LOCK_EN
//   defined   : cfg_lock_i on an accepted write locks the entry until reset;
//               writes to a locked entry are rejected.
//   undefined : no lock state, cfg_lock_i ignored.
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   req_valid_i/req_ready_o        lookup request handshake
//   req_addr_i                     address to classify
//   resp_valid_o/resp_ready_i      lookup result handshake
//   resp_hit_o, resp_idx_o         match flag and matching entry index
//   resp_cached_o, resp_nonidem_o,
//   resp_exec_o                    attributes of the matching entry
//   cfg_we_i, cfg_idx_i            entry write strobe and target index
//   cfg_base_i, cfg_len_i,
//   cfg_attr_i, cfg_lock_i         new entry contents and lock request
//   cfg_err_o                      one-cycle pulse: previous write rejected

module pma_region_table #(
  parameter int NrRules   = 4,
  parameter int AddrWidth = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0][2:0]           RstAttr   = '0,
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxW-1:0]      resp_idx_o,
  output logic                 resp_cached_o,
  output logic                 resp_nonidem_o,
  output logic                 resp_exec_o,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o
);

  localparam logic [IdxW:0] NrRulesW = (IdxW+1)'(NrRules);

  // Table storage
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] base_d [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [AddrWidth-1:0] len_d  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [2:0]           attr_d [NrRules];

  // Response slot
  logic            resp_valid_q, resp_valid_d;
  logic            resp_hit_q,   resp_hit_d;
  logic [IdxW-1:0] resp_idx_q,   resp_idx_d;
  logic [2:0]      resp_attr_q,  resp_attr_d;
  logic            cfg_err_q,    cfg_err_d;

  // ---------------------------------------------------------------------------
  // Lookup: region end is formed one bit wider so a region ending exactly at
  // 2^AddrWidth does not wrap to zero.
  // ---------------------------------------------------------------------------
  logic [AddrWidth:0] region_end [NrRules];
  logic [NrRules-1:0] match;

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    assign region_end[g] = {1'b0, base_q[g]} + {1'b0, len_q[g]};
    assign match[g] = (len_q[g] != '0) &&
                      (req_addr_i >= base_q[g]) &&
                      ({1'b0, req_addr_i} < region_end[g]);
  end

  logic            lk_hit;
  logic [IdxW-1:0] lk_idx;
  logic [2:0]      lk_attr;

  // Scan from the top so the lowest matching index is the last to overwrite.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_attr = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit  = 1'b1;
        lk_idx  = IdxW'(i);
        lk_attr = attr_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response slot handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_attr_d  = resp_attr_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = lk_hit;
      resp_idx_d   = lk_idx;
      resp_attr_d  = lk_attr;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Config write
  // ---------------------------------------------------------------------------
  logic idx_oob;
  logic idx_locked;
  logic cfg_ok;

  assign idx_oob = ({1'b0, cfg_idx_i} >= NrRulesW);

`ifdef PMA_REGION_TABLE_LOCK_EN
  logic [NrRules-1:0] lock_q, lock_d;

  // Selected by comparison rather than indexing so an out-of-range index
  // never addresses past the array.
  always_comb begin
    idx_locked = 1'b0;
    for (int i = 0; i < NrRules; i++) begin
      if (cfg_idx_i == IdxW'(i)) idx_locked = lock_q[i];
    end
  end
`else
  logic unused_cfg_lock;
  assign unused_cfg_lock = cfg_lock_i;
  assign idx_locked      = 1'b0;
`endif

  assign cfg_ok    = cfg_we_i && !idx_oob && !idx_locked;
  assign cfg_err_d = cfg_we_i && !cfg_ok;

  always_comb begin
    for (int i = 0; i < NrRules; i++) begin
      base_d[i] = base_q[i];
      len_d[i]  = len_q[i];
      attr_d[i] = attr_q[i];
      if (cfg_ok && (cfg_idx_i == IdxW'(i))) begin
        base_d[i] = cfg_base_i;
        len_d[i]  = cfg_len_i;
        attr_d[i] = cfg_attr_i;
      end
    end
  end

`ifdef PMA_REGION_TABLE_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    for (int i = 0; i < NrRules; i++) begin
      if (cfg_ok && cfg_lock_i && (cfg_idx_i == IdxW'(i))) lock_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= '0;
    else       lock_q <= lock_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
        attr_q[i] <= RstAttr[i];
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_attr_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= base_d[i];
        len_q[i]  <= len_d[i];
        attr_q[i] <= attr_d[i];
      end
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_attr_q  <= resp_attr_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = resp_hit_q;
  assign resp_idx_o     = resp_idx_q;
  assign resp_exec_o    = resp_attr_q[2];
  assign resp_nonidem_o = resp_attr_q[1];
  assign resp_cached_o  = resp_attr_q[0];
  assign cfg_err_o      = cfg_err_q;

endmodule

// File: tb/tb_pma_region_table.sv
// tb/tb_pma_region_table.sv - scoreboard bench for pma_region_table

module tb_pma_region_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main DUT: NrRules=4
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [1:0]  resp_idx;
  logic        resp_cached, resp_nonidem, resp_exec;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [63:0] cfg_base = '0;
  logic [63:0] cfg_len = '0;
  logic [2:0]  cfg_attr = '0;
  logic        cfg_lock = 1'b0;
  logic        cfg_err;

  // Second DUT: NrRules=5 so an out-of-range index (5) is representable
  logic        b_req_ready, b_resp_valid, b_resp_hit;
  logic [2:0]  b_resp_idx;
  logic        b_resp_cached, b_resp_nonidem, b_resp_exec;
  logic        b_cfg_we = 1'b0;
  logic [2:0]  b_cfg_idx = '0;
  logic        b_cfg_err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
    logic [2:0] attr;  // {exec, nonidem, cached}
  } exp_t;

  exp_t exp_q[$];

  pma_region_table #(.NrRules(4), .AddrWidth(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hit_o(resp_hit), .resp_idx_o(resp_idx),
    .resp_cached_o(resp_cached), .resp_nonidem_o(resp_nonidem), .resp_exec_o(resp_exec),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
    .cfg_attr_i(cfg_attr), .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err)
  );

  pma_region_table #(.NrRules(5), .AddrWidth(64)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(1'b0), .req_ready_o(b_req_ready), .req_addr_i(64'h0),
    .resp_valid_o(b_resp_valid), .resp_ready_i(1'b1),
    .resp_hit_o(b_resp_hit), .resp_idx_o(b_resp_idx),
    .resp_cached_o(b_resp_cached), .resp_nonidem_o(b_resp_nonidem), .resp_exec_o(b_resp_exec),
    .cfg_we_i(b_cfg_we), .cfg_idx_i(b_cfg_idx), .cfg_base_i(64'h1000), .cfg_len_i(64'h100),
    .cfg_attr_i(3'b001), .cfg_lock_i(1'b0), .cfg_err_o(b_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per transferred result.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got hit=%0b idx=%0d with empty scoreboard", resp_hit, resp_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp", {58'h0, resp_hit, resp_idx, resp_exec, resp_nonidem, resp_cached}, {58'h0, e});
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic lookup(input logic [63:0] addr, input exp_t e);
    bit done = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) check("lookup_timeout", 64'd0, 64'd1);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [63:0] base, input logic [63:0] len,
                           input logic [2:0] attr, input logic lock, input logic exp_err);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = base; cfg_len = len; cfg_attr = attr; cfg_lock = lock;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_lock = 1'b0;
    check("cfg_err_pulse", {63'h0, cfg_err}, {63'h0, exp_err});
    @(posedge clk); #1;
    check("cfg_err_clear", {63'h0, cfg_err}, 64'h0);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", {63'h0, resp_valid}, 64'h0);
    check("rst_outs", {58'h0, resp_hit, resp_idx, resp_exec, resp_nonidem, resp_cached}, 64'h0);
    check("rst_err", {63'h0, cfg_err}, 64'h0);
    check("rst_ready", {63'h0, req_ready}, 64'h1);

    // Empty table -> miss
    lookup(64'h8000_0000, '{hit:1'b0, idx:2'd0, attr:3'b000});
    drain();

    // idx1: [0x8000_0000, 0xC000_0000) cached
    cfg_write(2'd1, 64'h8000_0000, 64'h4000_0000, 3'b001, 1'b0, 1'b0);
    lookup(64'hBFFF_FFFF, '{hit:1'b1, idx:2'd1, attr:3'b001});
    lookup(64'hC000_0000, '{hit:1'b0, idx:2'd0, attr:3'b000});
    lookup(64'h8000_0000, '{hit:1'b1, idx:2'd1, attr:3'b001});
    lookup(64'h7FFF_FFFF, '{hit:1'b0, idx:2'd0, attr:3'b000});

    // Overlap: idx0 wins inside its 4 KiB, idx1 above it
    cfg_write(2'd0, 64'h8000_0000, 64'h1000, 3'b110, 1'b0, 1'b0);
    lookup(64'h8000_0800, '{hit:1'b1, idx:2'd0, attr:3'b110});
    lookup(64'h8000_1000, '{hit:1'b1, idx:2'd1, attr:3'b001});

    // Region ending exactly at 2^64
    cfg_write(2'd3, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b100, 1'b1, 1'b0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, '{hit:1'b1, idx:2'd3, attr:3'b100});
    lookup(64'hFFFF_FFFF_FFFF_EFFF, '{hit:1'b0, idx:2'd0, attr:3'b000});
    drain();

    // Backpressure: A held in the slot while B waits for 3 cycles
    resp_ready = 1'b0;
    lookup(64'hBFFF_FFFF, '{hit:1'b1, idx:2'd1, attr:3'b001});
    req_valid = 1'b1;
    req_addr  = 64'h8000_0800;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_low", {63'h0, req_ready}, 64'h0);
      check("bp_stable", {57'h0, resp_valid, resp_hit, resp_idx, resp_exec, resp_nonidem, resp_cached},
            {57'h0, 1'b1, 1'b1, 2'd1, 3'b001});
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {63'h0, req_ready}, 64'h1);
    exp_q.push_back('{hit:1'b1, idx:2'd0, attr:3'b110});
    @(posedge clk); #1;
    req_addr = 64'hC000_0000;
    @(negedge clk);
    check("stream_valid_b", {62'h0, resp_valid, req_ready}, 64'h3);
    exp_q.push_back('{hit:1'b0, idx:2'd0, attr:3'b000});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("stream_valid_c", {63'h0, resp_valid}, 64'h1);
    @(posedge clk); #1;
    drain();

    // Same-cycle write + lookup on idx2 sees old attributes
    cfg_write(2'd2, 64'h1000, 64'h1000, 3'b001, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_base = 64'h1000; cfg_len = 64'h1000; cfg_attr = 3'b110;
    req_valid = 1'b1; req_addr = 64'h1800;
    @(negedge clk);
    check("same_cycle_ready", {63'h0, req_ready}, 64'h1);
    exp_q.push_back('{hit:1'b1, idx:2'd2, attr:3'b001});
    @(posedge clk); #1;
    cfg_we = 1'b0; req_valid = 1'b0;
    lookup(64'h1800, '{hit:1'b1, idx:2'd2, attr:3'b110});
    drain();

    // Rewrite of idx3 after a write that requested a lock
`ifdef PMA_REGION_TABLE_LOCK_EN
    cfg_write(2'd3, 64'h0, 64'h10, 3'b001, 1'b0, 1'b1);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, '{hit:1'b1, idx:2'd3, attr:3'b100});
    lookup(64'h8, '{hit:1'b0, idx:2'd0, attr:3'b000});
`else
    cfg_write(2'd3, 64'h0, 64'h10, 3'b001, 1'b0, 1'b0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, '{hit:1'b0, idx:2'd0, attr:3'b000});
    lookup(64'h8, '{hit:1'b1, idx:2'd3, attr:3'b001});
`endif
    drain();

    // Out-of-range index on the 5-entry instance
    b_cfg_we = 1'b1; b_cfg_idx = 3'd5;
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
    check("oob_err_pulse", {63'h0, b_cfg_err}, 64'h1);
    @(posedge clk); #1;
    check("oob_err_clear", {63'h0, b_cfg_err}, 64'h0);
    b_cfg_we = 1'b1; b_cfg_idx = 3'd4;
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
    check("inrange_no_err", {63'h0, b_cfg_err}, 64'h0);

    // Reset with a pending response: slot dropped, table back to reset contents
    resp_ready = 1'b0;
    lookup(64'hBFFF_FFFF, '{hit:1'b1, idx:2'd1, attr:3'b001});
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'h0, resp_valid}, 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    lookup(64'hBFFF_FFFF, '{hit:1'b0, idx:2'd0, attr:3'b000});
    lookup(64'h8000_0800, '{hit:1'b0, idx:2'd0, attr:3'b000});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
